dwrr_queue_bank: RTL and testbench

//  Requestor side of the DWRR arbiter: bank of NUM_REQS per-flow packet FIFOs.

---
 rtl/dwrr_queue_bank.sv | 172 +++++++++++++++++
 tb/tb_dwrr_queue_bank.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/dwrr_queue_bank.sv
// dwrr_queue_bank: bank of NUM_REQS per-flow packet FIFOs feeding a DWRR arbiter.
// Upstream pushes tagged packets. Each non-empty queue raises its req bit. A legal
// one-hot grant pops that queue's head onto a registered output port one cycle later.
// Ports:
//   clk_i        clock; all state is updated on the rising edge
//   rst_ni       synchronous active-low reset
//   in_valid_i   upstream packet valid
//   in_id_i      target queue of the pushed packet
//   in_data_i    packet payload
//   in_ready_o   push is accepted when in_valid_i & in_ready_o (combinational)
//   gnt_i        one-hot grant from the arbiter
//   reqs_o       per-queue non-empty flags (combinational from occupancy)
//   out_valid_o  popped packet valid (registered)
//   out_id_o     queue the popped packet came from
//   out_data_o   popped payload
//   occ_o        packed per-queue occupancy, queue i at [(i+1)*OCCWID-1 : i*OCCWID]
//   proto_err_o  sticky flag for an illegal grant; cleared only by reset
module dwrr_queue_bank #(
    parameter int unsigned NUM_REQS = 4,
    parameter int unsigned DWID     = 8,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned IDWID    = $clog2(NUM_REQS),
    parameter int unsigned PTRWID   = $clog2(DEPTH),
    parameter int unsigned OCCWID   = $clog2(DEPTH + 1)
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       in_valid_i,
    input  logic [IDWID-1:0]           in_id_i,
    input  logic [DWID-1:0]            in_data_i,
    output logic                       in_ready_o,
    input  logic [NUM_REQS-1:0]        gnt_i,
    output logic [NUM_REQS-1:0]        reqs_o,
    output logic                       out_valid_o,
    output logic [IDWID-1:0]           out_id_o,
    output logic [DWID-1:0]            out_data_o,
    output logic [NUM_REQS*OCCWID-1:0] occ_o,
    output logic                       proto_err_o
);

    localparam int unsigned CNTWID = $clog2(NUM_REQS + 1);

    // Storage and per-queue state
    logic [DWID-1:0]   mem_q    [NUM_REQS][DEPTH];
    logic [PTRWID-1:0] wr_ptr_q [NUM_REQS];
    logic [PTRWID-1:0] wr_ptr_d [NUM_REQS];
    logic [PTRWID-1:0] rd_ptr_q [NUM_REQS];
    logic [PTRWID-1:0] rd_ptr_d [NUM_REQS];
    logic [OCCWID-1:0] occ_q    [NUM_REQS];
    logic [OCCWID-1:0] occ_d    [NUM_REQS];

    logic              out_valid_q, out_valid_d;
    logic [IDWID-1:0]  out_id_q,    out_id_d;
    logic [DWID-1:0]   out_data_q,  out_data_d;
    logic              proto_err_q, proto_err_d;

    logic [NUM_REQS-1:0] reqs_c;
    logic [NUM_REQS-1:0] push_c;
    logic [NUM_REQS-1:0] pop_c;
    logic                in_ready_c;
    logic [CNTWID-1:0]   gnt_cnt_c;
    logic                gnt_ok_c;
    logic                gnt_err_c;
    logic [IDWID-1:0]    pop_id_c;
    logic [DWID-1:0]     pop_data_c;

    // Circular pointer advance; DEPTH need not be a power of two
    function automatic logic [PTRWID-1:0] ptr_inc(input logic [PTRWID-1:0] p);
        return (p == PTRWID'(DEPTH - 1)) ? '0 : p + PTRWID'(1);
    endfunction

    // Request flags and push acceptance, from registered occupancy only
    always_comb begin
        in_ready_c = 1'b0;
        push_c     = '0;
        reqs_c     = '0;
        for (int unsigned i = 0; i < NUM_REQS; i++) begin
            reqs_c[i] = (occ_q[i] != '0);
            // Out-of-range ids match no queue and are never ready
            if (32'(in_id_i) == i) begin
                in_ready_c = (occ_q[i] != OCCWID'(DEPTH));
            end
        end
        for (int unsigned i = 0; i < NUM_REQS; i++) begin
            push_c[i] = in_valid_i & in_ready_c & (32'(in_id_i) == i);
        end
    end

    // Grant legality: exactly one bit set, and it must hit a non-empty queue
    always_comb begin
        gnt_cnt_c = '0;
        for (int unsigned i = 0; i < NUM_REQS; i++) begin
            gnt_cnt_c = gnt_cnt_c + CNTWID'(gnt_i[i]);
        end
        gnt_ok_c  = (gnt_cnt_c == CNTWID'(1)) & (|(gnt_i & reqs_c));
        gnt_err_c = (gnt_i != '0) & ~gnt_ok_c;
        pop_c     = gnt_ok_c ? gnt_i : '0;
    end

    // Head-of-line mux for the granted queue
    always_comb begin
        pop_id_c   = '0;
        pop_data_c = '0;
        for (int unsigned i = 0; i < NUM_REQS; i++) begin
            if (pop_c[i]) begin
                pop_id_c   = IDWID'(i);
                pop_data_c = mem_q[i][rd_ptr_q[i]];
            end
        end
    end

    // Next-state for pointers, occupancy and output port
    always_comb begin
        out_valid_d = |pop_c;
        out_id_d    = out_id_q;
        out_data_d  = out_data_q;
        proto_err_d = proto_err_q | gnt_err_c;
        for (int unsigned i = 0; i < NUM_REQS; i++) begin
            wr_ptr_d[i] = push_c[i] ? ptr_inc(wr_ptr_q[i]) : wr_ptr_q[i];
            rd_ptr_d[i] = pop_c[i]  ? ptr_inc(rd_ptr_q[i]) : rd_ptr_q[i];
            occ_d[i]    = occ_q[i] + OCCWID'(push_c[i]) - OCCWID'(pop_c[i]);
        end
        if (|pop_c) begin
            out_id_d   = pop_id_c;
            out_data_d = pop_data_c;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < NUM_REQS; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                occ_q[i]    <= '0;
            end
            out_valid_q <= 1'b0;
            out_id_q    <= '0;
            out_data_q  <= '0;
            proto_err_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            occ_q       <= occ_d;
            out_valid_q <= out_valid_d;
            out_id_q    <= out_id_d;
            out_data_q  <= out_data_d;
            proto_err_q <= proto_err_d;
        end
    end

    // Payload storage; stale entries after reset are unreachable since pointers clear
    always_ff @(posedge clk_i) begin
        for (int unsigned i = 0; i < NUM_REQS; i++) begin
            if (push_c[i]) begin
                mem_q[i][wr_ptr_q[i]] <= in_data_i;
            end
        end
    end

    for (genvar g = 0; g < NUM_REQS; g++) begin : g_occ
        assign occ_o[g*OCCWID +: OCCWID] = occ_q[g];
    end

    assign in_ready_o  = in_ready_c;
    assign reqs_o      = reqs_c;
    assign out_valid_o = out_valid_q;
    assign out_id_o    = out_id_q;
    assign out_data_o  = out_data_q;
    assign proto_err_o = proto_err_q;

endmodule

// File: tb/tb_dwrr_queue_bank.sv
// Bench for dwrr_queue_bank: directed vector table, a push/pop corner sequence,
// and random traffic compared against a queue-based reference model.
module tb_dwrr_queue_bank;

    localparam int unsigned N  = 4;
    localparam int unsigned DW = 8;
    localparam int unsigned D  = 4;
    localparam int unsigned IW = 2;
    localparam int unsigned OW = 3;

    logic            clk;
    logic            rst_n;
    logic            in_valid;
    logic [IW-1:0]   in_id;
    logic [DW-1:0]   in_data;
    logic            in_ready;
    logic [N-1:0]    gnt;
    logic [N-1:0]    reqs;
    logic            out_valid;
    logic [IW-1:0]   out_id;
    logic [DW-1:0]   out_data;
    logic [N*OW-1:0] occ;
    logic            proto_err;

    int total = 0;
    int bad   = 0;

    dwrr_queue_bank #(.NUM_REQS(N), .DWID(DW), .DEPTH(D)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .in_valid_i  (in_valid),
        .in_id_i     (in_id),
        .in_data_i   (in_data),
        .in_ready_o  (in_ready),
        .gnt_i       (gnt),
        .reqs_o      (reqs),
        .out_valid_o (out_valid),
        .out_id_o    (out_id),
        .out_data_o  (out_data),
        .occ_o       (occ),
        .proto_err_o (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: one SV queue per flow plus the output-port state
    logic [DW-1:0] mq [N][$];
    logic          m_ov;
    logic [IW-1:0] m_oid;
    logic [DW-1:0] m_od;
    logic          m_err;
    bit            m_ok = 0;

    function automatic logic m_ready();
        return (int'(in_id) < N) && (mq[in_id].size() != D);
    endfunction

    function automatic logic [N-1:0] m_reqs();
        logic [N-1:0] r = '0;
        for (int i = 0; i < N; i++) r[i] = (mq[i].size() != 0);
        return r;
    endfunction

    function automatic logic [N*OW-1:0] m_occ();
        logic [N*OW-1:0] o = '0;
        for (int i = 0; i < N; i++) o[i*OW +: OW] = OW'(mq[i].size());
        return o;
    endfunction

    // Apply one clock edge of the specified behaviour to the model
    task automatic mdl_step();
        int  ones = 0;
        int  idx  = 0;
        bit  rdy;
        if (!rst_n) begin
            for (int i = 0; i < N; i++) mq[i].delete();
            m_ov = 0; m_oid = '0; m_od = '0; m_err = 0; m_ok = 1;
            return;
        end
        rdy = m_ready();
        for (int i = 0; i < N; i++) if (gnt[i]) begin ones++; idx = i; end
        if (ones == 1 && mq[idx].size() > 0) begin
            m_od  = mq[idx].pop_front();
            m_oid = IW'(idx);
            m_ov  = 1;
        end else begin
            m_ov = 0;
            if (ones != 0) m_err = 1;
        end
        if (in_valid && rdy) mq[in_id].push_back(in_data);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic set_in(input logic r, input logic v, input logic [IW-1:0] id,
                          input logic [DW-1:0] d, input logic [N-1:0] g);
        rst_n = r; in_valid = v; in_id = id; in_data = d; gnt = g;
    endtask

    // One cycle: combinational checks before the edge, registered checks after it
    task automatic cycle();
        @(negedge clk);
        if (m_ok) begin
            chk("m_in_ready", 32'(in_ready), 32'(m_ready()));
            chk("m_reqs_pre", 32'(reqs), 32'(m_reqs()));
        end
        @(posedge clk);
        mdl_step();
        #1;
        if (m_ok) begin
            chk("m_occ",       32'(occ),       32'(m_occ()));
            chk("m_out_valid", 32'(out_valid), 32'(m_ov));
            chk("m_out_id",    32'(out_id),    32'(m_oid));
            chk("m_out_data",  32'(out_data),  32'(m_od));
            chk("m_proto_err", 32'(proto_err), 32'(m_err));
            chk("m_reqs",      32'(reqs),      32'(m_reqs()));
        end
    endtask

    typedef struct {
        logic            rst;
        logic            iv;
        logic [IW-1:0]   id;
        logic [DW-1:0]   d;
        logic [N-1:0]    g;
        logic            chk_rdy;
        logic            rdy;
        logic            ov;
        logic [IW-1:0]   oid;
        logic [DW-1:0]   od;
        logic [N-1:0]    rq;
        logic [N*OW-1:0] oc;
        logic            err;
    } vec_t;

    vec_t vt[$];

    initial begin
        set_in(0, 0, 0, 0, 0);

        //             rst iv id  d      g        cr rdy ov oid od     rq       occ      err
        // reset with traffic applied
        vt.push_back('{0, 1, 0, 8'h00, 4'b0001, 0, 0,  0, 0, 8'h00, 4'b0000, 12'h000, 0});
        vt.push_back('{0, 1, 0, 8'h00, 4'b0001, 0, 0,  0, 0, 8'h00, 4'b0000, 12'h000, 0});
        // two pushes to q2, two pops, then idle holds id/data
        vt.push_back('{1, 1, 2, 8'hA1, 4'b0000, 1, 1,  0, 0, 8'h00, 4'b0100, 12'h040, 0});
        vt.push_back('{1, 1, 2, 8'hA2, 4'b0000, 1, 1,  0, 0, 8'h00, 4'b0100, 12'h080, 0});
        vt.push_back('{1, 0, 2, 8'h00, 4'b0100, 1, 1,  1, 2, 8'hA1, 4'b0100, 12'h040, 0});
        vt.push_back('{1, 0, 2, 8'h00, 4'b0100, 1, 1,  1, 2, 8'hA2, 4'b0000, 12'h000, 0});
        vt.push_back('{1, 0, 2, 8'h00, 4'b0000, 1, 1,  0, 2, 8'hA2, 4'b0000, 12'h000, 0});
        // fill q1, fifth push dropped, q0 still ready
        vt.push_back('{1, 1, 1, 8'h11, 4'b0000, 1, 1,  0, 2, 8'hA2, 4'b0010, 12'h008, 0});
        vt.push_back('{1, 1, 1, 8'h12, 4'b0000, 1, 1,  0, 2, 8'hA2, 4'b0010, 12'h010, 0});
        vt.push_back('{1, 1, 1, 8'h13, 4'b0000, 1, 1,  0, 2, 8'hA2, 4'b0010, 12'h018, 0});
        vt.push_back('{1, 1, 1, 8'h14, 4'b0000, 1, 1,  0, 2, 8'hA2, 4'b0010, 12'h020, 0});
        vt.push_back('{1, 1, 1, 8'h15, 4'b0000, 1, 0,  0, 2, 8'hA2, 4'b0010, 12'h020, 0});
        vt.push_back('{1, 1, 0, 8'h01, 4'b0000, 1, 1,  0, 2, 8'hA2, 4'b0011, 12'h021, 0});
        // multi-hot grant: no pop, sticky error
        vt.push_back('{1, 0, 0, 8'h00, 4'b0011, 1, 1,  0, 2, 8'hA2, 4'b0011, 12'h021, 1});
        vt.push_back('{1, 0, 0, 8'h00, 4'b0000, 1, 1,  0, 2, 8'hA2, 4'b0011, 12'h021, 1});
        // reset discards everything; grant to empty q3 is an error
        vt.push_back('{0, 0, 0, 8'h00, 4'b0000, 1, 1,  0, 0, 8'h00, 4'b0000, 12'h000, 0});
        vt.push_back('{1, 0, 0, 8'h00, 4'b1000, 1, 1,  0, 0, 8'h00, 4'b0000, 12'h000, 1});
        vt.push_back('{0, 0, 0, 8'h00, 4'b0000, 1, 1,  0, 0, 8'h00, 4'b0000, 12'h000, 0});

        foreach (vt[k]) begin
            set_in(vt[k].rst, vt[k].iv, vt[k].id, vt[k].d, vt[k].g);
            #2;
            if (vt[k].chk_rdy) chk($sformatf("v%0d_in_ready", k), 32'(in_ready), 32'(vt[k].rdy));
            cycle();
            chk($sformatf("v%0d_out_valid", k), 32'(out_valid), 32'(vt[k].ov));
            chk($sformatf("v%0d_out_id", k),    32'(out_id),    32'(vt[k].oid));
            chk($sformatf("v%0d_out_data", k),  32'(out_data),  32'(vt[k].od));
            chk($sformatf("v%0d_reqs", k),      32'(reqs),      32'(vt[k].rq));
            chk($sformatf("v%0d_occ", k),       32'(occ),       32'(vt[k].oc));
            chk($sformatf("v%0d_proto_err", k), 32'(proto_err), 32'(vt[k].err));
        end

        // q3 at occupancy 2, then simultaneous push+pop with pointer wrap
        set_in(1, 1, 3, 8'h30, 4'b0000); cycle();
        set_in(1, 1, 3, 8'h31, 4'b0000); cycle();
        for (int k = 0; k < 6; k++) begin
            set_in(1, 1, 3, DW'(8'h32 + k), 4'b1000);
            cycle();
            chk("t4_occ3",      32'(occ[3*OW +: OW]), 32'd2);
            chk("t4_out_valid", 32'(out_valid),       32'd1);
            chk("t4_out_data",  32'(out_data),        32'(8'h30 + k));
        end
        set_in(1, 0, 3, 8'h00, 4'b1000); cycle();
        chk("t4_drain0", 32'(out_data), 32'h36);
        set_in(1, 0, 3, 8'h00, 4'b1000); cycle();
        chk("t4_drain1", 32'(out_data), 32'h37);
        chk("t4_empty",  32'(reqs),     32'h0);
        chk("t4_noerr",  32'(proto_err), 32'h0);

        // Random traffic against the model
        for (int n = 0; n < 600; n++) begin
            int unsigned r;
            int unsigned q;
            logic [N-1:0] g;
            r = $urandom_range(0, 99);
            q = $urandom_range(0, N - 1);
            g = '0;
            if (r < 60) begin
                if (mq[q].size() > 0) g = N'(1) << q;
            end else if (r < 64) begin
                g = N'($urandom_range(0, (1 << N) - 1));
            end
            set_in(($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1,
                   1'($urandom_range(0, 1)),
                   IW'($urandom_range(0, N - 1)),
                   DW'($urandom),
                   g);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
